// File: rtl/ram_pkg.sv
// ram_pkg: shared SRAM geometry and sequencer state encoding
package ram_pkg;
    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DATA_W = 5;
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
endpackage

// File: rtl/ram_seq_arbiter_if.sv
// ram_seq_arbiter_if: two-port client request/ack bundle
//   req/req_we/req_addr/req_wdata : per-port request, port p at slice p
//   ack/rdata/busy                : completion pulse, read data, sequencer busy
interface ram_seq_arbiter_if
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);
    logic [1:0]          req;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          ack;
    logic [DATA_W-1:0]   rdata;
    logic                busy;
    modport master (output req, req_we, req_addr, req_wdata, input ack, rdata, busy);
    modport slave  (input req, req_we, req_addr, req_wdata, output ack, rdata, busy);
endinterface

// File: rtl/ram_seq_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter
//   req : requests, en : grant allowed, last : port served last, grant : one-hot winner
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       last,
    output logic [1:0] grant
);
    always_comb grant = !en ? 2'b00 : (&req) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/ram_seq_arbiter.sv
// ram_seq_arbiter: shares one async SRAM between two clients with SETUP/STROBE/HOLD sequencing
//   clk/rst : clock, synchronous active-high reset
//   bus     : client request/ack bundle (slave side)
//   ram_*   : registered SRAM pins, active-low strobes, tristate data
module ram_seq_arbiter
    import ram_pkg::*;
#(
    parameter int ADDR_W     = RAM_ADDR_W,
    parameter int DATA_W     = RAM_DATA_W,
    parameter int STROBE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    ram_seq_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);
    state_t            state, nxt;
    logic [3:0]        cnt, n_cnt;
    logic              port_q, n_port, we_q, n_we, last, n_last, drive;
    logic [ADDR_W-1:0] addr_q, n_addr;
    logic [DATA_W-1:0] wdata_q, n_wdata;
    logic [1:0]        grant;

    rr_arb2 arb (.req(bus.req), .en(state == IDLE), .last(last), .grant(grant));

    always_comb begin
        nxt     = state;
        n_cnt   = cnt;
        n_port  = port_q;
        n_we    = we_q;
        n_addr  = addr_q;
        n_wdata = wdata_q;
        n_last  = last;
        case (state)
            IDLE: if (|grant) begin
                nxt     = SETUP;
                n_port  = grant[1];
                n_last  = grant[1];
                n_we    = grant[1] ? bus.req_we[1] : bus.req_we[0];
                n_addr  = grant[1] ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
                n_wdata = grant[1] ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
            end
            SETUP: begin
                nxt   = STROBE;
                n_cnt = 4'(STROBE_CYC - 1);
            end
            STROBE: begin
                nxt   = cnt == 4'd0 ? HOLD : STROBE;
                n_cnt = cnt == 4'd0 ? cnt : cnt - 4'd1;
            end
            default: nxt = IDLE;
        endcase
    end

    // Pins are registered from the next-state view so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            last      <= 1'b1;
            ram_ce_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            drive     <= 1'b0;
            bus.ack   <= 2'b00;
            bus.rdata <= '0;
        end else begin
            state     <= nxt;
            cnt       <= n_cnt;
            port_q    <= n_port;
            we_q      <= n_we;
            addr_q    <= n_addr;
            wdata_q   <= n_wdata;
            last      <= n_last;
            ram_ce_n  <= nxt == IDLE;
            ram_we_n  <= !(nxt == STROBE && n_we);
            ram_oe_n  <= !((nxt == SETUP || nxt == STROBE) && !n_we);
            drive     <= nxt != IDLE && n_we;
            bus.ack   <= state == HOLD ? (port_q ? 2'b10 : 2'b01) : 2'b00;
            if (state == STROBE && cnt == 4'd0 && !we_q)
                bus.rdata <= ram_data;
        end
    end

    assign ram_addr = addr_q;
    assign ram_data = drive ? wdata_q : 'z;
    assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_ram_seq_arbiter.sv
// tb_ram_seq_arbiter: directed checks on a STROBE_CYC=2 instance, random traffic on STROBE_CYC=1 and 15
module tb_ram_seq_arbiter;
    logic clk = 0;
    logic rst_d = 1, rst_r = 1;
    int   asserts = 0, fails = 0, ndone = 0;
    always #5 clk = ~clk;

    logic [1:0]  d_req = 0, d_we = 0;
    logic [11:0] d_addr = 0;
    logic [9:0]  d_wdata = 0;
    logic [1:0]  d_ack;
    logic [4:0]  d_rdata, d_data;
    logic [5:0]  d_ra;
    logic        d_busy, d_ce, d_oe, d_we_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int SC = g == 0 ? 2 : g == 1 ? 1 : 15;
        ram_seq_arbiter_if ifc ();
        logic [5:0]  ra;
        tri0  [4:0]  rd;
        logic        ce, oe, we;
        logic [4:0]  mem [64] = '{default: 0};
        logic [1:0]  r_req = 0, r_we = 0;
        logic [11:0] r_addr = 0;
        logic [9:0]  r_wdata = 0;
        wire         irst = g == 0 ? rst_d : rst_r;
        logic        p_low = 0, p_wlow = 0;
        logic [5:0]  p_addr = 0;
        logic [4:0]  p_data = 0;
        assign ifc.req       = g == 0 ? d_req : r_req;
        assign ifc.req_we    = g == 0 ? d_we : r_we;
        assign ifc.req_addr  = g == 0 ? d_addr : r_addr;
        assign ifc.req_wdata = g == 0 ? d_wdata : r_wdata;
        ram_seq_arbiter #(.STROBE_CYC(SC)) dut (
            .clk(clk), .rst(irst), .bus(ifc), .ram_addr(ra), .ram_data(rd),
            .ram_ce_n(ce), .ram_oe_n(oe), .ram_we_n(we)
        );
        // asynchronous SRAM: drives on CE&OE, latches on the rising WE edge
        assign rd = (!ce && !oe) ? mem[ra] : 5'bz;
        always @(posedge we) if (!ce) mem[ra] <= rd;

        always @(negedge clk) begin
            if (!irst) begin
                chk("oe_we_excl", {31'b0, oe | we}, 1);
                chk("ack_onehot", {31'b0, ifc.ack != 2'b11}, 1);
                if (!oe) chk("no_drive_on_read", rd, mem[ra]);
                if ((!oe || !we) && p_low) chk("addr_stable", ra, p_addr);
                if (!we && p_wlow) chk("data_stable", rd, p_data);
            end
            p_low  <= !irst && (!oe || !we);
            p_wlow <= !irst && !we;
            p_addr <= ra;
            p_data <= rd;
        end

        if (g == 0) begin : o
            assign d_ack = ifc.ack;   assign d_rdata = ifc.rdata; assign d_busy = ifc.busy;
            assign d_data = rd;       assign d_ra = ra;
            assign d_ce = ce;         assign d_oe = oe;           assign d_we_n = we;
        end else begin : rnd
            initial begin
                logic       pend [2];
                logic       pw [2];
                logic [5:0] pa [2];
                logic [4:0] pd [2];
                int         age [2];
                logic [4:0] model [64];
                for (int i = 0; i < 64; i++) model[i] = 0;
                for (int p = 0; p < 2; p++) begin pend[p] = 0; pw[p] = 0; pa[p] = 0; pd[p] = 0; age[p] = 0; end
                wait (rst_r == 0);
                for (int c = 0; c < 900; c++) begin
                    @(negedge clk);
                    for (int p = 0; p < 2; p++) begin
                        if (pend[p]) age[p]++;
                        if (ifc.ack[p]) begin
                            chk("rnd_ack_pending", {31'b0, pend[p]}, 1);
                            if (pend[p]) begin
                                chk("rnd_lat_min", {31'b0, age[p] >= 3 + SC}, 1);
                                chk("rnd_lat_max", {31'b0, age[p] <= 6 + 2 * SC}, 1);
                                if (pw[p]) model[pa[p]] = pd[p];
                                else chk("rnd_rdata", ifc.rdata, model[pa[p]]);
                            end
                            pend[p] = 0;
                            r_req[p] = 0;
                        end else if (pend[p] && age[p] == 7 + 2 * SC) begin
                            chk("rnd_ack_timeout", age[p], 6 + 2 * SC);
                            pend[p] = 0;
                            r_req[p] = 0;
                        end
                        if (!pend[p] && c < 850 && $urandom_range(2) == 0) begin
                            pend[p] = 1; age[p] = 0;
                            pw[p] = 1'($urandom); pa[p] = 6'($urandom_range(7)); pd[p] = 5'($urandom);
                            r_req[p] = 1; r_we[p] = pw[p];
                            r_addr[p*6 +: 6] = pa[p]; r_wdata[p*5 +: 5] = pd[p];
                        end
                    end
                end
                for (int p = 0; p < 2; p++) chk("rnd_drained", {31'b0, pend[p]}, 0);
                ndone++;
            end
        end
    end

    task automatic do_op(input int p, input logic w, input logic [5:0] a, input logic [4:0] dt,
                         output int lat, output logic [4:0] rv, output int wl, output int ol,
                         output logic [4:0] dv);
        d_req[p] = 1; d_we[p] = w; d_addr[p*6 +: 6] = a; d_wdata[p*5 +: 5] = dt;
        lat = -1; rv = 0; wl = 0; ol = 0; dv = 0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            wl += int'(!d_we_n);
            ol += int'(!d_oe);
            if (!d_we_n) dv = d_data;
            if (d_ack[p]) begin lat = n; rv = d_rdata; end
        end
        d_req[p] = 0;
    endtask

    initial begin
        int lat, wl, ol, a0, a1, nack, exp_p, last_t;
        logic [4:0] rv, dv;
        repeat (3) @(negedge clk);
        chk("rst_ce", {31'b0, d_ce}, 1);
        chk("rst_oe", {31'b0, d_oe}, 1);
        chk("rst_we", {31'b0, d_we_n}, 1);
        chk("rst_data_z", d_data, 0);
        chk("rst_addr", d_ra, 0);
        chk("rst_ack", d_ack, 0);
        chk("rst_rdata", d_rdata, 0);
        chk("rst_busy", {31'b0, d_busy}, 0);
        rst_d = 0; rst_r = 0;
        @(negedge clk);
        // write then read back on port 0
        do_op(0, 1, 6'h05, 5'h1A, lat, rv, wl, ol, dv);
        chk("t1_wr_lat", lat, 5);
        chk("t1_we_low_cycles", wl, 2);
        chk("t1_wr_bus", dv, 5'h1A);
        chk("t1_wr_oe_cycles", ol, 0);
        chk("t1_released", d_data, 0);
        chk("t1_ce_idle", {31'b0, d_ce}, 1);
        do_op(0, 0, 6'h05, 5'h00, lat, rv, wl, ol, dv);
        chk("t1_rd_lat", lat, 5);
        chk("t1_rdata", rv, 5'h1A);
        chk("t1_rd_we_cycles", wl, 0);
        chk("t1_oe_low_cycles", ol, 3);
        // simultaneous requests right after reset: port 0 wins the tie
        rst_d = 1; @(negedge clk); rst_d = 0; @(negedge clk);
        d_we = 2'b11; d_addr = {6'h00, 6'h3F}; d_wdata = {5'h0E, 5'h11}; d_req = 2'b11;
        a0 = -1; a1 = -1;
        for (int n = 1; n <= 40 && (a0 < 0 || a1 < 0); n++) begin
            @(negedge clk);
            if (d_ack[0]) begin a0 = n; d_req[0] = 0; end
            if (d_ack[1]) begin a1 = n; d_req[1] = 0; end
        end
        d_req = 0;
        chk("t2_ack0", a0, 5);
        chk("t2_ack1", a1, 10);
        do_op(0, 0, 6'h3F, 5'h00, lat, rv, wl, ol, dv);
        chk("t2_rd3f", rv, 5'h11);
        do_op(1, 0, 6'h00, 5'h00, lat, rv, wl, ol, dv);
        chk("t2_rd00", rv, 5'h0E);
        // both ports hold req: strict alternation starting with the port not served last
        d_we = 0; d_addr = {6'h02, 6'h01}; d_req = 2'b11;
        nack = 0; exp_p = 0; last_t = 0;
        for (int n = 1; n <= 80 && nack < 6; n++) begin
            @(negedge clk);
            if (|d_ack) begin
                chk("t3_order", {31'b0, d_ack[1]}, exp_p);
                chk("t3_busy_idle", {31'b0, d_busy}, 0);
                if (nack > 0) chk("t3_gap", n - last_t, 5);
                last_t = n; exp_p = 1 - exp_p; nack++;
                if (nack == 6) d_req = 0;
            end
        end
        d_req = 0;
        chk("t3_count", nack, 6);
        repeat (2) @(negedge clk);
        // request latched at grant: drop req and change fields afterwards
        do_op(0, 1, 6'h20, 5'h15, lat, rv, wl, ol, dv);
        d_req[1] = 1; d_we[1] = 1; d_addr[11:6] = 6'h10; d_wdata[9:5] = 5'h07;
        @(negedge clk);
        d_req[1] = 0; d_we[1] = 0; d_addr[11:6] = 6'h20; d_wdata[9:5] = 5'h1F;
        lat = -1;
        for (int n = 2; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (d_ack[1]) lat = n;
        end
        chk("t4_ack_lat", lat, 5);
        do_op(0, 0, 6'h10, 5'h00, lat, rv, wl, ol, dv);
        chk("t4_rd10", rv, 5'h07);
        do_op(0, 0, 6'h20, 5'h00, lat, rv, wl, ol, dv);
        chk("t4_rd20", rv, 5'h15);
        // reset during the write strobe
        d_req[0] = 1; d_we[0] = 1; d_addr[5:0] = 6'h08; d_wdata[4:0] = 5'h0B;
        wl = 0;
        for (int n = 1; n <= 20 && wl == 0; n++) begin
            @(negedge clk);
            wl = int'(!d_we_n);
        end
        chk("t5_reached_strobe", wl, 1);
        rst_d = 1;
        @(negedge clk);
        chk("t5_ce", {31'b0, d_ce}, 1);
        chk("t5_oe", {31'b0, d_oe}, 1);
        chk("t5_we", {31'b0, d_we_n}, 1);
        chk("t5_data_z", d_data, 0);
        chk("t5_busy", {31'b0, d_busy}, 0);
        rst_d = 0; d_req = 0;
        nack = 0;
        repeat (10) begin
            @(negedge clk);
            nack += int'(|d_ack);
        end
        chk("t5_no_ack", nack, 0);
        do_op(1, 1, 6'h09, 5'h13, lat, rv, wl, ol, dv);
        chk("t5_after_lat", lat, 5);
        do_op(1, 0, 6'h09, 5'h00, lat, rv, wl, ol, dv);
        chk("t5_after_rd", rv, 5'h13);
        for (int n = 0; n < 2000 && ndone < 2; n++) @(negedge clk);
        chk("rnd_finished", ndone, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
